// File: rtl/imem_loader_if.sv
// Byte-stream receive channel plus instruction-memory write port of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a 16-bit little-endian word count followed by that many
// little-endian 32-bit words and writes them to instruction memory from address 0.
module imem_loader #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  imem_loader_if.master  bus,
  output logic           core_rst,
  output logic           load_done,
  output logic           load_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e      state, state_nxt;

  logic [7:0]  len_lo;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] byte_buf;
  logic [31:0] waddr_q;
  logic [31:0] wdata_q;

  logic        rx_ready_c;
  logic        xfer;
  logic        begin_ses;
  logic [15:0] len_in;
  logic        len_zero;
  logic        len_ovf;
  logic        last_word;

  assign xfer      = bus.rx_valid & rx_ready_c;
  assign begin_ses = start & ((state == IDLE) | (state == DONE));
  assign len_in    = {bus.rx_data, len_lo};
  assign len_zero  = (len_in == 16'd0);
  // 17-bit compare so a depth of 65536 is still handled as unsigned
  assign len_ovf   = ({1'b0, len_in} > 17'(IMEM_DEPTH));
  assign last_word = ((17'(word_idx) + 17'd1) == {1'b0, count});

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = LEN_LO;
      LEN_LO: if (xfer)  state_nxt = LEN_HI;
      LEN_HI: if (xfer)  state_nxt = (len_zero || len_ovf) ? DONE : DATA;
      DATA:   if (xfer && byte_idx == 2'd3) state_nxt = WRITE;
      WRITE:  state_nxt = last_word ? DONE : DATA;
      DONE:   if (start) state_nxt = LEN_LO;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- outputs decoded from state ----
  always_comb begin
    rx_ready_c  = 1'b0;
    core_rst    = 1'b0;
    bus.imem_we = 1'b0;
    unique case (state)
      LEN_LO, LEN_HI, DATA: begin
        rx_ready_c = 1'b1;
        core_rst   = 1'b1;
      end
      WRITE: begin
        core_rst    = 1'b1;
        bus.imem_we = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rx_ready   = rx_ready_c;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;

  // ---- datapath: length capture, byte assembly, write port, status ----
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo    <= '0;
      count     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      byte_buf  <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (begin_ses) begin
        len_lo    <= '0;
        count     <= '0;
        word_idx  <= '0;
        byte_idx  <= '0;
        byte_buf  <= '0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end
      unique case (state)
        LEN_LO: if (xfer) len_lo <= bus.rx_data;
        LEN_HI: if (xfer) begin
          count <= len_in;
          if (len_zero || len_ovf) begin
            load_done <= 1'b1;
            load_err  <= len_ovf;
          end
        end
        DATA: if (xfer) begin
          byte_idx <= byte_idx + 2'd1;
          // shift-in keeps the first byte of the word in the low lane
          byte_buf <= {bus.rx_data, byte_buf[23:8]};
          if (byte_idx == 2'd3) begin
            waddr_q <= {14'd0, word_idx, 2'b00};
            wdata_q <= {bus.rx_data, byte_buf};
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          if (last_word) load_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: sessions are generated, expected
// writes queued from a byte-level model, and a monitor checks every write strobe.
module tb_imem_loader;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic core_rst, load_done, load_err;

  always #5 clk = ~clk;

  imem_loader_if bus();

  imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  fixed_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (bus.imem_we) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %h data %h expected none", bus.imem_waddr, bus.imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", bus.imem_waddr, e.addr);
          chk("wdata", bus.imem_wdata, e.data);
        end
        chk("ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
      end else if (core_rst) begin
        chk("ready_in_session", {31'd0, bus.rx_ready}, 32'd1);
      end else begin
        chk("ready_outside_session", {31'd0, bus.rx_ready}, 32'd0);
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the byte has transferred
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    bus.rx_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_byte: got no rx_ready expected ready within 20 cycles");
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values();
    chk("rst_rx_ready",  {31'd0, bus.rx_ready}, 32'd0);
    chk("rst_imem_we",   {31'd0, bus.imem_we},  32'd0);
    chk("rst_waddr",     bus.imem_waddr,        32'd0);
    chk("rst_wdata",     bus.imem_wdata,        32'd0);
    chk("rst_core_rst",  {31'd0, core_rst},     32'd0);
    chk("rst_load_done", {31'd0, load_done},    32'd0);
    chk("rst_load_err",  {31'd0, load_err},     32'd0);
  endtask

  // one load session; rst_after >= 0 asserts rst after that many data bytes
  task automatic run_session(input int cnt, input bit toggle, input bit mid_start, input int rst_after);
    logic [7:0]  b[$];
    logic [31:0] words[$];
    logic [15:0] len;
    logic [31:0] w;
    bit          valid_len;
    bit          seen;
    len       = 16'(cnt);
    valid_len = (cnt > 0) && (cnt <= DEPTH);

    if (valid_len) begin
      if (fixed_q.size() == 4 * cnt) b = fixed_q;
      else for (int i = 0; i < 4 * cnt; i++) b.push_back(8'($urandom_range(0, 255)));
      fixed_q.delete();
      for (int i = 0; i < cnt; i++) begin
        w = 32'(b[4*i]) + (32'(b[4*i+1]) << 8) + (32'(b[4*i+2]) << 16) + (32'(b[4*i+3]) << 24);
        words.push_back(w);
        if (rst_after < 0 || 4 * (i + 1) <= rst_after)
          exp_q.push_back('{addr: 32'(4 * i), data: w});
      end
    end

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_done_clr", {31'd0, load_done}, 32'd0);
    chk("start_err_clr",  {31'd0, load_err},  32'd0);
    chk("start_core_rst", {31'd0, core_rst},  32'd1);
    @(posedge clk);
    #1;

    send_byte(len[7:0]);
    if (toggle) idle_cycles(1);
    send_byte(len[15:8]);

    for (int k = 0; k < b.size(); k++) begin
      if (k == rst_after) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        chk("rst_pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        return;
      end
      if (toggle) idle_cycles(1);
      else if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      if (mid_start && k == 5) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      send_byte(b[k]);
      if ((k % 4) == 3) begin
        @(negedge clk);
        chk("we_latency", {31'd0, bus.imem_we}, 32'd1);
        @(posedge clk);
        #1;
      end
    end

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = load_done;
    end
    chk("load_done",     {31'd0, load_done},    32'd1);
    chk("load_err",      {31'd0, load_err},     {31'd0, (cnt > DEPTH)});
    chk("end_rx_ready",  {31'd0, bus.rx_ready}, 32'd0);
    chk("end_core_rst",  {31'd0, core_rst},     32'd0);
    chk("end_imem_we",   {31'd0, bus.imem_we},  32'd0);
    chk("end_pending",   32'(exp_q.size()),     32'd0);
    if (valid_len) begin
      chk("hold_waddr", bus.imem_waddr, 32'(4 * (cnt - 1)));
      chk("hold_wdata", bus.imem_wdata, words[cnt-1]);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of run expected finish before 900us");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst          = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle_cycles(3);
    start        = 1'b1;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;

    // directed two-word program
    fixed_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_session(2, 1'b0, 1'b0, -1);
    chk("prog_last_word", bus.imem_wdata, 32'h0010_0093);
    run_session(0, 1'b0, 1'b0, -1);              // empty image
    run_session(DEPTH + 1, 1'b0, 1'b0, -1);      // overflow by one
    run_session(1, 1'b1, 1'b0, -1);              // rx_valid toggling
    run_session(2, 1'b0, 1'b0, 6);               // reset mid second word
    run_session(3, 1'b0, 1'b0, -1);              // clean reload after reset
    run_session(3, 1'b0, 1'b1, -1);              // start during DATA ignored
    run_session(2, 1'b0, 1'b0, -1);              // restart from DONE
    run_session(DEPTH, 1'b0, 1'b0, -1);          // fills memory to the top
    run_session(16'hFFFF, 1'b0, 1'b0, -1);       // largest count

    for (int s = 0; s < 16; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      run_session(0, 1'b0, 1'b0, -1);
      else if (r == 1) run_session(DEPTH + 1 + $urandom_range(0, 1000), 1'b0, 1'b0, -1);
      else             run_session($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 256, capacity of the target instruction memory in 32-bit words.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 start  input  1  single-cycle request to begin a load session.
REQ-005 rx_valid  input  1  byte-stream source has a byte on rx_data.
REQ-006 rx_data  input  8  incoming byte.
REQ-007 rx_ready  output  1  loader accepts rx_data this cycle.
REQ-008 imem_we  output  1  write strobe to instruction memory, one cycle per word.
REQ-009 imem_waddr  output  32  byte address of the word being written, always word-aligned.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 core_rst  output  1  holds the fetch pipeline in reset while a session is active.
REQ-012 load_done  output  1  level: last session finished, successfully or not.
REQ-013 load_err  output  1  level: last session rejected for overflow.

Function
REQ-014 A byte transfers only on a cycle with rx_valid=1 and rx_ready=1; rx_ready does not depend on rx_valid.
REQ-015 FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE.
REQ-016 IDLE: rx_ready=0; start=1 -> LEN_LO, clear load_done, load_err, word counter, byte index, address.
REQ-017 LEN_LO: rx_ready=1; on transfer latch count[7:0] -> LEN_HI.
REQ-018 LEN_HI: rx_ready=1; on transfer latch count[15:8], then: count=0 -> DONE (err=0); count>IMEM_DEPTH -> DONE with load_err=1 and no writes; else -> DATA.
REQ-019 DATA: rx_ready=1; bytes assemble little-endian (1st byte -> [7:0], 4th -> [31:24]); byte index 0..3 wraps; 4th transfer -> WRITE.
REQ-020 WRITE: rx_ready=0; imem_we=1 for exactly this one cycle with imem_waddr=4*word_index and imem_wdata=assembled word; word_index increments; if word_index+1=count -> DONE, else -> DATA.
REQ-021 Latency: imem_we asserts the cycle after the 4th byte of a word transfers; one idle byte slot per word.
REQ-022 DONE: rx_ready=0, load_done=1; start=1 -> LEN_LO (reload permitted, flags cleared as in REQ-016).
REQ-023 core_rst=1 in LEN_LO, LEN_HI, DATA, WRITE; 0 in IDLE and DONE.
REQ-024 start in any state other than IDLE or DONE is ignored.
REQ-025 Stalls (rx_valid=0) in any receiving state hold all state; no timeout.
REQ-026 imem_waddr and imem_wdata hold last written values outside WRITE; imem_we=0 outside WRITE.
REQ-027 count is 16-bit unsigned; comparison against IMEM_DEPTH is unsigned; address never exceeds 4*(IMEM_DEPTH-1).

Reset
REQ-028 rst=1 on any cycle, including mid-session, forces IDLE next cycle and discards partial words; writes already performed stay in memory.
REQ-029 Reset values: rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst=0, load_done=0, load_err=0, counters 0.
REQ-030 rst has priority over start and rx_valid on the same cycle.

Verification
REQ-031 start; bytes 02 00, 13 00 00 00, 93 00 10 00 -> writes 0x00000013@0x0, 0x00100093@0x4; load_done=1, load_err=0, core_rst 1 then 0.
REQ-032 start; bytes 00 00 -> DONE after LEN_HI, no imem_we, load_done=1, load_err=0.
REQ-033 start; bytes 01 01 (count 257, IMEM_DEPTH=256) -> no imem_we, load_done=1, load_err=1, rx_ready=0.
REQ-034 start; count 1 with rx_valid toggling 1/0 every cycle -> single write of correct word; rx_ready low only in WRITE/DONE.
REQ-035 start; count 2; assert rst after 6th data byte -> IDLE, only word 0 written, all outputs at reset values; new start reloads cleanly.
REQ-036 start pulsed during DATA -> ignored, session completes unchanged; start in DONE -> new session, load_done cleared.
